fb_port_arbiter: RTL
====================

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, framebuffer address width ({pixel_y[8:1], pixel_x[7:0]}).
REQ-002 Parameter DATA_W, default 3, pixel width (RGB).
REQ-003 Parameter FIFO_DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-004 clk  in  1  single system clock (pixel clock); all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rd_en  in  1  scan-out read request; driven from video_on.
REQ-007 rd_addr  in  ADDR_W  scan-out pixel address.
REQ-008 rd_data  out  DATA_W  scan-out pixel to RGB output.
REQ-009 wr_valid  in  1  host write request.
REQ-010 wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-011 wr_addr  in  ADDR_W  host write address.
REQ-012 wr_data  in  DATA_W  host write pixel.
REQ-013 mem_addr  out  ADDR_W  single-port framebuffer address.
REQ-014 mem_we  out  1  framebuffer write strobe.
REQ-015 mem_wdata  out  DATA_W  framebuffer write data.
REQ-016 mem_q  in  DATA_W  framebuffer read data, valid one cycle after address.
REQ-017 wr_count  out  16  committed-write counter.

Function
REQ-018 The port SHALL be granted to scan-out in any cycle with rd_en=1: mem_addr=rd_addr, mem_we=0, combinationally.
REQ-019 Host writes SHALL enter a FIFO_DEPTH-entry FIFO; wr_ready = !full, registered, so no push is accepted when full even if a pop occurs that cycle.
REQ-020 In a cycle with rd_en=0 and the FIFO non-empty, the block SHALL pop the head and drive mem_addr/mem_wdata from it with mem_we=1.
REQ-021 In a cycle with rd_en=0 and the FIFO empty, the block SHALL drive mem_we=0 and mem_addr=rd_addr.
REQ-022 rd_data SHALL be a register loaded with mem_q one cycle after a read cycle (2-cycle latency rd_en→rd_data) and held otherwise.
REQ-023 FSM states: IDLE (rd_en=0, FIFO empty), SCAN (rd_en=1), DRAIN (rd_en=0, FIFO non-empty); next state is a pure function of rd_en and post-update occupancy; SCAN preempts DRAIN immediately, with the un-issued head retained.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged and preserve write order.
REQ-025 Writes to the same address SHALL commit in acceptance order; the last one accepted wins.
REQ-026 wr_count SHALL increment by 1 per cycle with mem_we=1 and wrap from 0xFFFF to 0x0000.
REQ-027 Read and pointer arithmetic SHALL wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.

Reset
REQ-028 On reset: state=IDLE, FIFO empty, wr_ready=0 while reset is asserted and 1 from the first clock after release, rd_data=0, wr_count=0, mem_we=0.
REQ-029 Reset asserted mid-DRAIN SHALL discard all buffered writes and force mem_we=0 asynchronously.

Structure
REQ-030 Shared package fb_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state encoding.
REQ-031 The FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, full/empty flags).

Verification
REQ-032 rd_en=0, push 3 writes (0x0010/5, 0x0011/6, 0x0012/7) → mem_we on 3 consecutive cycles in order, wr_count=3.
REQ-033 rd_en=1 continuous, push 5 writes with FIFO_DEPTH=4 → 4 accepted, wr_ready=0 on the 5th, mem_we stays 0; drop rd_en → 4 writes commit.
REQ-034 rd_en=1 at rd_addr=0x0100 with mem model holding 3 → rd_data=3 two cycles later; mid-DRAIN rd_en rising → mem_we=0 that same cycle and the head is committed after rd_en falls.
REQ-035 Two writes to 0x0200 with data 1 then 4 → memory holds 4.
REQ-036 Reset pulse with 2 buffered writes → no further mem_we, wr_count=0, wr_ready=1 one cycle after release.
REQ-037 Preload wr_count=0xFFFF via 65535 writes, one more write → wr_count=0x0000.

Source files
------------

// File: rtl/fb_port_arbiter_pkg.sv
// Shared definitions for the framebuffer port arbiter: default widths,
// the committed-write counter width and the arbiter state encoding.
package fb_pkg;

    localparam int ADDR_W_DEFAULT     = 16;
    localparam int DATA_W_DEFAULT     = 3;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int WR_COUNT_W         = 16;

    // Who owns the framebuffer port in a given cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bundle of scan-out, host-write and framebuffer-memory signals around
// the arbiter. The arbiter uses the slave view; the host/memory side
// (or a bench) uses the master view.
interface fb_port_arbiter_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_q;
    logic [WR_COUNT_W-1:0] wr_count;

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, mem_q,
        output rd_data, wr_ready, mem_addr, mem_we, mem_wdata, wr_count
    );

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data, mem_q,
        input  rd_data, wr_ready, mem_addr, mem_we, mem_wdata, wr_count
    );

endinterface

// File: rtl/fb_port_arbiter_sync_fifo.sv
// Small synchronous FIFO holding pending host writes. The head entry is
// presented combinationally so it can be issued in the same cycle it is
// popped. A push while full is ignored even if a pop happens that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             full_next,
    output logic             empty_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign dout       = storage[rd_ptr];
    assign full_next  = (count_next == DEPTH_C);
    assign empty_next = (count_next == '0);

    // Occupancy after this cycle's push/pop; both at once leaves it unchanged
    always_comb begin
        count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // Entry storage needs no reset; the occupancy count guards validity
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= din;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter. Scan-out reads always win the port;
// host writes are buffered and drained into the framebuffer in cycles
// where scan-out is idle. Read data comes back two cycles after the
// request and is held until the next read.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    fb_port_arbiter_if.slave  bus
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    fb_state_t             state;
    fb_state_t             state_next;
    logic [ENTRY_W-1:0]    head;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_full_next;
    logic                  fifo_empty_next;
    logic                  push;
    logic                  pop;
    logic                  wr_ready_q;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W-1:0]     rd_data_q;
    logic [WR_COUNT_W-1:0] wr_count_q;

    assign head_addr = head[ENTRY_W-1:DATA_W];
    assign head_data = head[DATA_W-1:0];
    assign push      = bus.wr_valid && wr_ready_q && !fifo_full;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .din        ({bus.wr_addr, bus.wr_data}),
        .dout       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .full_next  (fifo_full_next),
        .empty_next (fifo_empty_next)
    );

    // State register; SCAN marks that the previous cycle issued a read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Port steering and next state from rd_en and post-update occupancy
    always_comb begin
        state_next = IDLE;
        mem_addr   = bus.rd_addr;
        mem_we     = 1'b0;
        pop        = 1'b0;
        if (bus.rd_en) begin
            state_next = SCAN;
        end else begin
            if (!fifo_empty) begin
                mem_addr = head_addr;
                mem_we   = 1'b1;
                pop      = 1'b1;
            end
            state_next = fifo_empty_next ? IDLE : DRAIN;
        end
    end

    // Write ready reflects next-cycle fullness; held low during reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_ready_q <= 1'b0;
        else       wr_ready_q <= !fifo_full_next;
    end

    // Capture memory output the cycle after a read was issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              rd_data_q <= '0;
        else if (state == SCAN) rd_data_q <= bus.mem_q;
    end

    // Count committed writes, wrapping at the counter width
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       wr_count_q <= '0;
        else if (mem_we) wr_count_q <= wr_count_q + WR_COUNT_W'(1);
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = head_data;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.wr_count  = wr_count_q;

endmodule
